wb_regfile: RTL and testbench

- Consumer end of the write-back stage of the RV32I core: accepts the retired-instruction bundle (W_PC/W_INST/W_VALID/W_REG_D/W_REG_D_V) and commits it to the architectural register file.
- Provides two read ports to decode, with same-cycle write-through bypass.
- Maintains the retirement state: 64-bit cycle and instret counters, and the last retired PC/instruction.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/wb_regfile_if.sv | 27 ++
 rtl/wb_regfile_retire_counter.sv | 24 ++
 rtl/wb_regfile.sv | 79 +++++++
 tb/tb_wb_regfile.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: widths, register-index constants and the
// retire bundle handed from the write-back stage to the register file.
package cpu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREG      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned CNT_W     = 64;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      inst;
        logic                 valid;
        logic [REG_IDX_W-1:0] reg_d;
        logic [XLEN-1:0]      reg_d_v;
    } retire_t;

    // x0 reads as zero; otherwise a same-cycle write wins over the stored value.
    function automatic logic [XLEN-1:0] bypass_sel(
        input logic [REG_IDX_W-1:0] idx,
        input logic                 wr_en,
        input logic [REG_IDX_W-1:0] wr_idx,
        input logic [XLEN-1:0]      wr_val,
        input logic [XLEN-1:0]      arr_val
    );
        if (idx == REG_ZERO) begin
            return '0;
        end else if (wr_en && (idx == wr_idx)) begin
            return wr_val;
        end else begin
            return arr_val;
        end
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back/decode bus of the register file: the retire bundle plus the two
// decode read ports.
interface wb_regfile_if import cpu_pkg::*; ();

    retire_t              wb;
    logic [REG_IDX_W-1:0] d_reg_s1;
    logic [REG_IDX_W-1:0] d_reg_s2;
    logic [XLEN-1:0]      d_reg_s1_v;
    logic [XLEN-1:0]      d_reg_s2_v;

    modport master (
        output wb,
        output d_reg_s1,
        output d_reg_s2,
        input  d_reg_s1_v,
        input  d_reg_s2_v
    );

    modport slave (
        input  wb,
        input  d_reg_s1,
        input  d_reg_s2,
        output d_reg_s1_v,
        output d_reg_s2_v
    );

endinterface

// File: rtl/wb_regfile_retire_counter.sv
// Free-running retirement counter with enable and async active-low clear;
// wraps silently at the top of its range.
module retire_counter #(
    parameter int unsigned Width = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [Width-1:0] count
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/wb_regfile.sv
// Write-back consumer: commits retired instructions into the architectural
// register file, serves two bypassed decode reads and tracks retirement state.
module wb_regfile
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    wb_regfile_if.slave        bus,
    output logic [CNT_W-1:0]   cycle,
    output logic [CNT_W-1:0]   instret,
    output logic [XLEN-1:0]    r_pc,
    output logic [XLEN-1:0]    r_inst,
    output logic               r_valid
);

    logic            commit;
    logic            wr_en;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] r_pc_q;
    logic [XLEN-1:0] r_inst_q;
    logic            r_valid_q;

    assign commit = bus.wb.valid & ~stall;
    assign wr_en  = commit & (bus.wb.reg_d != REG_ZERO);

    // x0 is never written, so its storage stays at the reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.wb.reg_d] <= bus.wb.reg_d_v;
        end
    end

    always_comb begin
        bus.d_reg_s1_v = bypass_sel(bus.d_reg_s1, wr_en, bus.wb.reg_d, bus.wb.reg_d_v,
                                    regs_q[bus.d_reg_s1]);
        bus.d_reg_s2_v = bypass_sel(bus.d_reg_s2, wr_en, bus.wb.reg_d, bus.wb.reg_d_v,
                                    regs_q[bus.d_reg_s2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_q    <= '0;
            r_inst_q  <= '0;
            r_valid_q <= 1'b0;
        end else if (commit) begin
            r_pc_q    <= bus.wb.pc;
            r_inst_q  <= bus.wb.inst;
            r_valid_q <= 1'b1;
        end
    end

    assign r_pc    = r_pc_q;
    assign r_inst  = r_inst_q;
    assign r_valid = r_valid_q;

    retire_counter #(
        .Width (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .count (cycle)
    );

    retire_counter #(
        .Width (CNT_W)
    ) u_instret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (commit),
        .count (instret)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_wb_regfile;
    import cpu_pkg::*;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall = 1'b0;
    logic [CNT_W-1:0] cycle;
    logic [CNT_W-1:0] instret;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_inst;
    logic             r_valid;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .bus     (bus),
        .cycle   (cycle),
        .instret (instret),
        .r_pc    (r_pc),
        .r_inst  (r_inst),
        .r_valid (r_valid)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [XLEN-1:0]  m_regs [NREG];
    logic [CNT_W-1:0] m_cycle;
    logic [CNT_W-1:0] m_instret;
    logic [XLEN-1:0]  m_pc;
    logic [XLEN-1:0]  m_inst;
    logic             m_valid;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_cycle   = '0;
        m_instret = '0;
        m_pc      = '0;
        m_inst    = '0;
        m_valid   = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] exp_read(input logic [REG_IDX_W-1:0] idx);
        if (idx == 0) return '0;
        if (bus.wb.valid && !stall && bus.wb.reg_d != 0 && idx == bus.wb.reg_d)
            return bus.wb.reg_d_v;
        return m_regs[idx];
    endfunction

    task automatic check_state();
        check("cycle", cycle, m_cycle);
        check("instret", instret, m_instret);
        check("r_pc", {32'd0, r_pc}, {32'd0, m_pc});
        check("r_inst", {32'd0, r_inst}, {32'd0, m_inst});
        check("r_valid", {63'd0, r_valid}, {63'd0, m_valid});
    endtask

    // Called at a negedge; drives one cycle, checks reads before the edge and
    // registered state at the following negedge.
    task automatic step(input logic st, input logic v, input logic [4:0] rd,
                        input logic [31:0] val, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [4:0] s1, input logic [4:0] s2);
        stall          = st;
        bus.wb.valid   = v;
        bus.wb.reg_d   = rd;
        bus.wb.reg_d_v = val;
        bus.wb.pc      = pc;
        bus.wb.inst    = inst;
        bus.d_reg_s1   = s1;
        bus.d_reg_s2   = s2;
        #1;
        check("rd_s1", {32'd0, bus.d_reg_s1_v}, {32'd0, exp_read(s1)});
        check("rd_s2", {32'd0, bus.d_reg_s2_v}, {32'd0, exp_read(s2)});
        @(posedge clk);
        m_cycle = m_cycle + 1;
        if (v && !st) begin
            m_instret = m_instret + 1;
            m_pc      = pc;
            m_inst    = inst;
            m_valid   = 1'b1;
            if (rd != 0) m_regs[rd] = val;
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic bubble(input logic [4:0] s1, input logic [4:0] s2);
        step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, s1, s2);
    endtask

    initial begin
        logic [4:0]  rd;
        logic [63:0] ins0;
        model_reset();
        bus.wb     = '0;
        bus.d_reg_s1 = '0;
        bus.d_reg_s2 = '0;
        #12;
        check("reset_cycle", cycle, 64'd0);
        check("reset_rvalid", {63'd0, r_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) bubble(5'(i), 5'(i + 10));
        check("idle_cycle5", cycle, 64'd5);
        check("idle_instret0", instret, 64'd0);

        // Bypass then array read
        stall = 1'b0;
        bus.wb.valid = 1'b1; bus.wb.reg_d = 5'd5; bus.wb.reg_d_v = 32'hDEADBEEF;
        bus.d_reg_s1 = 5'd5;
        #1;
        check("bypass_x5", {32'd0, bus.d_reg_s1_v}, 64'hDEADBEEF);
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0000_1000, 32'h0000_0013, 5'd5, 5'd0);
        bubble(5'd5, 5'd5);
        check("array_x5", {32'd0, bus.d_reg_s1_v}, 64'hDEADBEEF);
        check("instret1", instret, 64'd1);
        check("rpc_1000", {32'd0, r_pc}, 64'h1000);

        // x0 writes discarded
        step(1'b0, 1'b1, 5'd0, 32'h12345678, 32'h1004, 32'h0000_0033, 5'd0, 5'd0);
        bubble(5'd0, 5'd0);
        check("x0_zero", {32'd0, bus.d_reg_s1_v}, 64'd0);
        check("x0_instret", instret, 64'd2);

        // Stall for three cycles, then release
        ins0 = instret;
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 32'h1008, 32'h1, 5'd7, 5'd7);
        check("stall_x7", {32'd0, bus.d_reg_s1_v}, 64'd0);
        check("stall_instret", instret, ins0);
        step(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 32'h1008, 32'h1, 5'd7, 5'd7);
        bubble(5'd7, 5'd7);
        check("unstall_x7", {32'd0, bus.d_reg_s2_v}, 64'hA5A5A5A5);
        check("unstall_instret", instret, ins0 + 1);

        // Back-to-back writes to x3 with both ports reading it
        for (int i = 1; i <= 3; i++)
            step(1'b0, 1'b1, 5'd3, 32'(i), 32'h2000 + 32'(i), 32'h2, 5'd3, 5'd3);
        bubble(5'd3, 5'd3);
        check("b2b_x3", {32'd0, bus.d_reg_s1_v}, 64'd3);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            rd = 5'($urandom_range(0, 31));
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), rd, $urandom(),
                 $urandom(), $urandom(),
                 ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)));
        end

        // Counter wrap through a hierarchical deposit
        dut.u_cycle_cnt.cnt_q   = '1;
        dut.u_instret_cnt.cnt_q = '1;
        m_cycle   = '1;
        m_instret = '1;
        step(1'b0, 1'b1, 5'd9, 32'h55, 32'h3000, 32'h3, 5'd9, 5'd0);
        check("wrap_cycle", cycle, 64'd0);
        check("wrap_instret", instret, 64'd0);

        // Async reset mid-cycle with a commit in flight
        stall = 1'b0;
        bus.wb.valid = 1'b1; bus.wb.reg_d = 5'd11; bus.wb.reg_d_v = 32'hCAFE_F00D;
        bus.d_reg_s1 = 5'd9; bus.d_reg_s2 = 5'd12;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cycle", cycle, 64'd0);
        check("arst_rvalid", {63'd0, r_valid}, 64'd0);
        check("arst_rpc", {32'd0, r_pc}, 64'd0);
        check("arst_x9", {32'd0, bus.d_reg_s1_v}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bubble(5'd11, 5'd9);
        check("arst_x11", {32'd0, bus.d_reg_s1_v}, 64'd0);
        check("arst_cycle1", cycle, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
